// File: rtl/id_ex_pipe_buf.sv
// ID/EX pipeline buffer: valid/ready handshake, kill-to-bubble, synchronous flush.
// Define PIPE_SKID_EN for the 2-entry skid buffer; otherwise a single entry is kept.
module id_ex_pipe_buf #(
    parameter int CTRL_WIDTH = 10,
    parameter int DATA_WIDTH = 143
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_kill,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            count
);

    logic [CTRL_WIDTH-1:0] head_ctrl_r;
    logic [CTRL_WIDTH-1:0] head_ctrl_nxt_s;
    logic [DATA_WIDTH-1:0] head_data_r;
    logic [DATA_WIDTH-1:0] head_data_nxt_s;
    logic [1:0]            count_r;
    logic [1:0]            count_nxt_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  out_valid_s;
    logic                  in_ready_s;
    logic [CTRL_WIDTH-1:0] in_ctrl_eff_s;

    assign out_valid_s   = (count_r != 2'd0);
    assign pop_s         = out_valid_s && out_ready;
    assign push_s        = in_valid && in_ready_s && !flush;
    // A killed entry still occupies a slot, but as a bubble with no side effects.
    assign in_ctrl_eff_s = in_kill ? {CTRL_WIDTH{1'b0}} : in_ctrl;

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_ctrl  = out_valid_s ? head_ctrl_r : {CTRL_WIDTH{1'b0}};
    assign out_data  = head_data_r;

`ifdef PIPE_SKID_EN

    logic [CTRL_WIDTH-1:0] skid_ctrl_r;
    logic [CTRL_WIDTH-1:0] skid_ctrl_nxt_s;
    logic [DATA_WIDTH-1:0] skid_data_r;
    logic [DATA_WIDTH-1:0] skid_data_nxt_s;

    // Readiness depends only on registered occupancy, breaking the out_ready path.
    assign in_ready_s = (count_r != 2'd2);
    assign count      = count_r;

    // Next-state for the head/skid pair and occupancy.
    always_comb begin
        head_ctrl_nxt_s = head_ctrl_r;
        head_data_nxt_s = head_data_r;
        skid_ctrl_nxt_s = skid_ctrl_r;
        skid_data_nxt_s = skid_data_r;
        count_nxt_s     = count_r;
        if (flush) begin
            count_nxt_s     = 2'd0;
            head_ctrl_nxt_s = {CTRL_WIDTH{1'b0}};
            skid_ctrl_nxt_s = {CTRL_WIDTH{1'b0}};
        end else begin
            case (count_r)
                2'd0: begin
                    if (push_s) begin
                        head_ctrl_nxt_s = in_ctrl_eff_s;
                        head_data_nxt_s = in_data;
                        count_nxt_s     = 2'd1;
                    end else begin
                        count_nxt_s     = 2'd0;
                    end
                end
                2'd1: begin
                    if (push_s && pop_s) begin
                        head_ctrl_nxt_s = in_ctrl_eff_s;
                        head_data_nxt_s = in_data;
                        count_nxt_s     = 2'd1;
                    end else if (push_s) begin
                        skid_ctrl_nxt_s = in_ctrl_eff_s;
                        skid_data_nxt_s = in_data;
                        count_nxt_s     = 2'd2;
                    end else if (pop_s) begin
                        count_nxt_s     = 2'd0;
                    end else begin
                        count_nxt_s     = 2'd1;
                    end
                end
                2'd2: begin
                    if (pop_s) begin
                        head_ctrl_nxt_s = skid_ctrl_r;
                        head_data_nxt_s = skid_data_r;
                        count_nxt_s     = 2'd1;
                    end else begin
                        count_nxt_s     = 2'd2;
                    end
                end
                default: begin
                    count_nxt_s     = 2'd0;
                    head_ctrl_nxt_s = {CTRL_WIDTH{1'b0}};
                    skid_ctrl_nxt_s = {CTRL_WIDTH{1'b0}};
                end
            endcase
        end
    end

    // Skid entry storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_ctrl_r <= {CTRL_WIDTH{1'b0}};
            skid_data_r <= {DATA_WIDTH{1'b0}};
        end else begin
            skid_ctrl_r <= skid_ctrl_nxt_s;
            skid_data_r <= skid_data_nxt_s;
        end
    end

`else

    // Single entry: may accept in the same cycle the head is consumed.
    assign in_ready_s = !out_valid_s || out_ready;
    assign count      = {1'b0, count_r[0]};

    // Next-state for the single head entry.
    always_comb begin
        head_ctrl_nxt_s = head_ctrl_r;
        head_data_nxt_s = head_data_r;
        count_nxt_s     = count_r;
        if (flush) begin
            count_nxt_s     = 2'd0;
            head_ctrl_nxt_s = {CTRL_WIDTH{1'b0}};
        end else if (push_s) begin
            head_ctrl_nxt_s = in_ctrl_eff_s;
            head_data_nxt_s = in_data;
            count_nxt_s     = 2'd1;
        end else if (pop_s) begin
            count_nxt_s     = 2'd0;
        end else begin
            count_nxt_s     = count_r;
        end
    end

`endif

    // Head entry and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_ctrl_r <= {CTRL_WIDTH{1'b0}};
            head_data_r <= {DATA_WIDTH{1'b0}};
            count_r     <= 2'd0;
        end else begin
            head_ctrl_r <= head_ctrl_nxt_s;
            head_data_r <= head_data_nxt_s;
            count_r     <= count_nxt_s;
        end
    end

endmodule

// File: doc/id_ex_pipe_buf.md
# id_ex_pipe_buf

Parametrised ID/EX pipeline stage buffer that carries a control bundle and a datapath payload from decode to execute. It adds a valid/ready handshake, per-entry bubble insertion (kill), synchronous flush, and an optional 2-entry skid buffer, so stalls no longer drop or duplicate instructions. It sits between the decode stage (hazard unit drives `in_kill`/`flush`) and the execute stage.

## Interface
Parameters:
- `CTRL_WIDTH`, default 10: control bundle width (reg/mem write enables, ALU select, A/B/WB selects, PC select); zeroed on bubble/flush.
- `DATA_WIDTH`, default 143: payload width (rs1/rs2 data, immediate, PC_next, opcode, rs1/rs2/rd addresses); never zeroed except at reset.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous flush of all entries.
- `in_valid` in 1: decode presents an entry.
- `in_ready` out 1: buffer can accept.
- `in_kill` in 1: store the accepted entry as a bubble (ctrl forced to 0).
- `in_ctrl` in CTRL_WIDTH: control bundle.
- `in_data` in DATA_WIDTH: payload.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: execute consumes head.
- `out_ctrl` out CTRL_WIDTH: head control; 0 whenever `out_valid`=0.
- `out_data` out DATA_WIDTH: head payload.
- `count` out 2: occupied entries (0..2).

## Operation
- Push = `in_valid && in_ready && !flush`; pop = `out_valid && out_ready`.
- Entries: head (drives outputs) and skid; `count` is a register tracking occupancy.
- Push with `in_kill`=1: entry occupies a slot, `out_valid` asserts for it, ctrl stored as 0, data stored as given.
- count=0, push: entry -> head; count 1.
- count=1: push only -> skid, count 2; pop only -> count 0; push+pop -> entry -> head, count 1.
- count=2: `in_ready`=0; pop -> skid moves to head, count 1.
- `in_ready` = (count != 2), a function of registered state only; no combinational path from `out_ready`.
- `out_valid` = (count != 0). `out_ctrl` = head ctrl gated by `out_valid`. `out_data` holds the last head value when empty.
- Flush takes priority over push and pop: count -> 0, head/skid ctrl -> 0, data registers unchanged, the pushed entry is discarded.
- Reset: count 0, all ctrl/data registers 0; `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=1.

## Timing
- Latency: an entry pushed at edge N is on `out_*` after edge N (visible in cycle N+1).
- Throughput: 1 entry/cycle when `out_ready` is held high.
- Stall: entries are held stable, with no duplication or loss, for any `out_ready` pattern.
- Flush cycle: `in_ready` reflects pre-flush count; after the edge, count=0.
- Reset asserted mid-operation: outputs clear immediately, asynchronously.

## Configuration
- `PIPE_SKID_EN` defined: 2-entry skid buffer as above.
- Not defined: single entry only. `in_ready` = `!out_valid || out_ready` (combinational). Push with pop replaces head. `count` is max 1, bit 1 tied to 0. Kill, flush and reset behaviour are unchanged.

## Test plan
- Streaming: `out_ready`=1, push ctrl 0x155/data 0x1..0x5 on consecutive cycles -> same sequence on outputs one cycle later, `count`=1, no gaps.
- Backpressure (skid on): `out_ready`=0, push A,B -> `count`=2, `in_ready`=0, third entry not accepted. Raise `out_ready` -> A then B in order, `in_ready`=1 after first pop.
- Kill: push ctrl 0x3FF with `in_kill`=1, data 0xABC -> `out_valid`=1, `out_ctrl`=0, `out_data`=0xABC.
- Flush: `count`=2, assert `flush` with `in_valid`=1 -> after edge, `count`=0, `out_valid`=0, `out_ctrl`=0, pushed entry absent.
- Reset: assert `reset_n`=0 mid-stream between edges -> `out_valid`/`out_ctrl`/`out_data`/`count` = 0 immediately, `in_ready`=1.
- Macro off: `out_ready`=0 with head full -> `in_ready`=0. Toggle `out_ready`=1 with `in_valid`=1 -> same-cycle replace, `count` stays 1.
